// File: rtl/dmem_port_arbiter_if.sv
// Shared-dmem bus: two requester ports (processor, DMA) plus the single dmem port.
// master = requesters and dmem side, slave = the arbiter.
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              p_req;
  logic              d_req;
  logic              p_wren;
  logic              d_wren;
  logic [ADDR_W-1:0] p_addr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] d_wdata;
  logic              d_lock;
  logic              p_gnt;
  logic              d_gnt;
  logic              p_rvalid;
  logic              d_rvalid;
  logic [DATA_W-1:0] p_rdata;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  modport master (
    output p_req, d_req, p_wren, d_wren, p_addr, d_addr, p_wdata, d_wdata, d_lock, q_dmem,
    input  p_gnt, d_gnt, p_rvalid, d_rvalid, p_rdata, d_rdata, address_dmem, data, wren
  );

  modport slave (
    input  p_req, d_req, p_wren, d_wren, p_addr, d_addr, p_wdata, d_wdata, d_lock, q_dmem,
    output p_gnt, d_gnt, p_rvalid, d_rvalid, p_rdata, d_rdata, address_dmem, data, wren
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port dmem between processor and DMA,
// with a bounded DMA burst lock and tagged read-data return after RD_LAT cycles.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input logic                clock,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  typedef enum logic {ST_RR, ST_BURST} state_e;

  state_e            state_q, state_d;
  logic              p_first_q, p_first_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d, burst_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        tag_q [RD_LAT];
  logic [1:0]        tag_push;
  logic              p_gnt_c, d_gnt_c, wren_c;
  logic              contested, locked;

  // State register; tag bit1 marks a processor read, bit0 a DMA read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_RR;
      p_first_q   <= 1'b1;
      burst_cnt_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      p_first_q   <= p_first_d;
      burst_cnt_q <= burst_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tag_q[0]    <= tag_push;
      for (int unsigned i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Arbitration, burst tracking and dmem port mux.
  always_comb begin
    state_d     = state_q;
    p_first_d   = p_first_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_c      = 1'b0;
    tag_push    = '0;
    p_gnt_c     = 1'b0;
    d_gnt_c     = 1'b0;
    contested   = bus.p_req && bus.d_req;
    locked      = (state_q == ST_BURST) && bus.d_req && bus.d_lock;
    burst_inc   = (state_q == ST_BURST)
                ? ((burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + CNT_W'(1))
                : CNT_W'(1);

    if (reset) begin
      if (locked)          d_gnt_c = 1'b1;
      else if (contested)  begin p_gnt_c = p_first_q; d_gnt_c = !p_first_q; end
      else if (bus.p_req)  p_gnt_c = 1'b1;
      else if (bus.d_req)  d_gnt_c = 1'b1;
    end

    if (p_gnt_c) begin
      addr_d   = bus.p_addr;
      data_d   = bus.p_wdata;
      wren_c   = bus.p_wren;
      tag_push = {!bus.p_wren, 1'b0};
    end else if (d_gnt_c) begin
      addr_d   = bus.d_addr;
      data_d   = bus.d_wdata;
      wren_c   = bus.d_wren;
      tag_push = {1'b0, !bus.d_wren};
    end

    if (contested && (p_gnt_c || d_gnt_c)) p_first_d = d_gnt_c;

    // A burst that hits the limit hands the next contested slot to the processor.
    if (d_gnt_c && bus.d_lock) begin
      if (burst_inc >= BURST_LIMIT) begin
        state_d     = ST_RR;
        burst_cnt_d = '0;
        p_first_d   = 1'b1;
      end else begin
        state_d     = ST_BURST;
        burst_cnt_d = burst_inc;
      end
    end else begin
      state_d     = ST_RR;
      burst_cnt_d = '0;
    end
  end

  assign bus.p_gnt        = p_gnt_c;
  assign bus.d_gnt        = d_gnt_c;
  assign bus.wren         = wren_c;
  assign bus.address_dmem = addr_d;
  assign bus.data         = data_d;
  assign bus.p_rvalid     = reset && tag_q[RD_LAT-1][1];
  assign bus.d_rvalid     = reset && tag_q[RD_LAT-1][0];
  assign bus.p_rdata      = bus.q_dmem;
  assign bus.d_rdata      = bus.q_dmem;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter that shares the single-port data memory (dmem syncram) between the processor and a secondary master (debug/loader DMA). It sits between the processor's dmem outputs and the dmem instance in the top-level wrapper, issuing at most one access per cycle. It also returns read data to the originating requester after the fixed memory latency. Round-robin arbitration with a bounded lock/burst mode guarantees that neither requester starves.

## Interface
- ADDR_W, 12: dmem word-address width.
- DATA_W, 32: data width.
- RD_LAT, 1: dmem read latency in cycles, from the address cycle to valid q. Legal range 1–4.
- MAX_BURST, 8: maximum consecutive grants to one locked requester. Legal range 1–255.

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- p_req / d_req  in  1  processor / DMA access request.
- p_wren / d_wren  in  1  1 = write, 0 = read.
- p_addr / d_addr  in  ADDR_W  access address.
- p_wdata / d_wdata  in  DATA_W  write data.
- d_lock  in  1  DMA requests back-to-back grants (burst).
- p_gnt / d_gnt  out  1  access accepted this cycle; combinational.
- p_rvalid / d_rvalid  out  1  read data valid for that requester; one-cycle pulse.
- p_rdata / d_rdata  out  DATA_W  read data, qualified by *_rvalid.
- address_dmem  out  ADDR_W  to dmem.
- data  out  DATA_W  to dmem.
- wren  out  1  to dmem.
- q_dmem  in  DATA_W  from dmem.

## Operation
- Requester handshake:
  - Assert req with stable wren/addr/wdata.
  - The access is taken in the cycle where req and gnt are both 1.
  - The requester may change its inputs or drop req only after that cycle.
- Exactly one of p_gnt and d_gnt is high when any req is high; both are 0 when neither req is high.
- Winner's wren, addr and wdata are driven combinationally to wren, address_dmem and data.
- With no grant: wren = 0; address_dmem and data hold their last values. This saves toggling and is not functionally required.
- State machine:
  - RR: normal round-robin.
    - Only one req high: that requester wins.
    - Both req high: the requester that did not win the last contested grant wins.
    - Last-winner pointer updates only on a contested grant.
    - After reset, the processor wins the first contested grant.
  - BURST: entered when d_gnt fires with d_lock = 1.
    - DMA wins unconditionally while d_req and d_lock stay high.
    - burst_cnt counts d grants in the burst, including the entry grant.
    - Return to RR when any of: d_lock = 0, d_req = 0, or burst_cnt reaches MAX_BURST.
    - On a MAX_BURST exit, the pointer is set so the processor wins the next contested grant.
- Read return:
  - Each read grant pushes a tag (p/d) into an RD_LAT-deep shift register.
  - At the tail, the matching *_rvalid pulses and *_rdata = q_dmem.
  - Writes push "none".
  - p_rdata and d_rdata both mirror q_dmem; only rvalid differs.
- Simultaneous events:
  - A read return and a new grant in the same cycle are independent; full throughput is one access per cycle.
  - d_lock asserted while in RR with p_req also high: normal RR applies, and BURST is entered only on a d grant.

## Timing
- Grant: same cycle as req (combinational).
- Read latency: *_rvalid rises exactly RD_LAT cycles after the grant cycle.
- Writes: committed by dmem in the grant cycle; no response.
- Reset (reset = 0 at a clock edge):
  - state = RR, pointer = processor-first, burst_cnt = 0, tag pipeline cleared.
  - wren = 0, address_dmem = 0, data = 0, *_rvalid = 0.
  - Gnt outputs are forced to 0 while reset = 0.
- Reset mid-burst or with reads in flight: in-flight reads are discarded and no rvalid is produced for them.
- burst_cnt is 8 bits and saturates. It never wraps, because exit occurs at MAX_BURST.

## Test plan
- Single read:
  - Stimulus: p_req with addr 0x010, dmem[0x010] = 0xDEADBEEF.
  - Required: p_gnt in cycle 0, p_rvalid with 0xDEADBEEF in cycle RD_LAT, d_rvalid stays 0.
- Contention, both reading, 6 cycles, no lock:
  - Stimulus: p_req and d_req held high for 6 cycles.
  - Required: grants alternate P,D,P,D,P,D starting with P; each rvalid returns to the correct requester with the correct data.
- Burst, MAX_BURST = 4:
  - Stimulus: d_lock = 1, d_req and p_req held high.
  - Required: after P wins, D wins 4 consecutive grants, then P wins; bursting resumes only on the next D grant.
- Write then read:
  - Stimulus: d writes 0x12345678 to 0xFFF (top address), then p reads 0xFFF.
  - Required: p_rvalid returns 0x12345678; wren is high only in the write cycle.
- Reset mid-burst:
  - Stimulus: reset = 0 during the cycle after a read grant, with lock active.
  - Required: no rvalid emerges; all outputs return to reset values; the first contested grant after release goes to P.
- Idle:
  - Stimulus: no req for 10 cycles.
  - Required: wren = 0, both gnt = 0, both rvalid = 0 throughout.
